dec_scan_seq: RTL

//  Sequencer that sits directly upstream of the 3-to-8 hierarchical decoder and drives its enable and
//  3-bit select. It steps addresses start_addr..end_addr with wrap-around 7->0. Each address is held
//  for a programmable number of cycles. Modes: single sweep, or continuous sweeps until stop.
//  The decoder's one-hot outputs then strobe one of 8 downstream lines per dwell window.

---
 rtl/dec_scan_pkg.sv | 19 +
 rtl/dec_scan_seq_dwell_timer.sv | 29 ++
 rtl/dec_scan_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dec_scan_pkg.sv
// Shared definitions for the decoder scan sequencer.
//   state_t   : FSM encoding (IDLE / ACTIVE / DONE)
//   ADDR_W    : decoder select width
//   NUM_LINES : downstream strobe lines behind the 3-to-8 decoder
//   addr_inc  : next select value, wraps 7 -> 0
package dec_scan_pkg;
  localparam int ADDR_W    = 3;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + 1'b1;  // natural 3-bit overflow gives the 7 -> 0 wrap
  endfunction
endpackage

// File: rtl/dec_scan_seq_dwell_timer.sv
// Dwell timer: counts cycles spent on the current address.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force count to 0 (config load)
//   run        : count enable (sequencer active and not aborting)
//   hold       : freeze count (stall)
//   dwell_eff  : cycles per address, already forced >= 1
//   expire     : count has reached dwell_eff-1; the count self-clears on the
//                next running cycle
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               run,
  input  logic               hold,
  input  logic [DWELL_W-1:0] dwell_eff,
  output logic               expire
);
  logic [DWELL_W-1:0] cnt;

  assign expire = (cnt == dwell_eff - 1'b1);

  always_ff @(posedge clk) begin
    if (!rst_n)           cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (run && !hold) cnt <= expire ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/dec_scan_seq.sv
// Scan sequencer feeding a 3-to-8 decoder: walks start_addr..end_addr
// (wrapping 7 -> 0), holding each address for `dwell` cycles, once or
// continuously until stop.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, stop         : begin sweep (IDLE only) / abort active sweep
//   continuous          : repeat sweeps; sampled at start
//   stall               : freeze dwell count and address
//   start_addr/end_addr : sweep bounds; sampled at start
//   dwell               : cycles per address (0 acts as 1); sampled at start
//   dec_en, dec_addr    : decoder enable / select
//   busy, done, aborted : status; done pulses one cycle, aborted qualifies it
//   sweep_cnt           : sweeps completed since last start
module dec_scan_seq
  import dec_scan_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic               stall,
  input  logic [2:0]         start_addr,
  input  logic [2:0]         end_addr,
  input  logic [DWELL_W-1:0] dwell,
  output logic               dec_en,
  output logic [2:0]         dec_addr,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [SWEEP_W-1:0] sweep_cnt
);
  state_t             state, state_nx;
  logic [ADDR_W-1:0]  cfg_start, cfg_end;
  logic               cfg_cont;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               load, expire, step, last;

  assign load = (state == IDLE) && start && !stop;
  // stop overrides stall and expiry, so an aborting cycle never steps
  assign step = (state == ACTIVE) && !stop && !stall && expire;
  assign last = (dec_addr == cfg_end);

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (load),
    .run       ((state == ACTIVE) && !stop),
    .hold      (stall),
    .dwell_eff (cfg_dwell),
    .expire    (expire)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load) state_nx = ACTIVE;
      ACTIVE:  if (stop || (step && last && !cfg_cont)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // registered outputs and sweep datapath; values are set on the edge that
  // enters a state so they line up with the state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_en    <= 1'b0;
      dec_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      sweep_cnt <= '0;
      cfg_start <= '0;
      cfg_end   <= '0;
      cfg_cont  <= 1'b0;
      cfg_dwell <= DWELL_W'(1);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (load) begin
          cfg_start <= start_addr;
          cfg_end   <= end_addr;
          cfg_cont  <= continuous;
          cfg_dwell <= (dwell == '0) ? DWELL_W'(1) : dwell;
          dec_addr  <= start_addr;
          sweep_cnt <= '0;
          aborted   <= 1'b0;
          dec_en    <= 1'b1;
          busy      <= 1'b1;
        end
        ACTIVE: begin
          if (stop) begin
            dec_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (step) begin
            if (!last) begin
              dec_addr <= addr_inc(dec_addr);
            end else begin
              sweep_cnt <= sweep_cnt + 1'b1;
              if (cfg_cont) begin
                dec_addr <= cfg_start;
              end else begin
                dec_en <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
